func_seq_ctrl: RTL and testbench

//  Sequencer in front of func_unit for multi-pass ops (RRAM/RRCM/RLAM-style repeats, chained ADDC).

---
 rtl/func_seq_if.sv | 35 +++
 rtl/func_seq_ctrl.sv | 115 +++++++++++
 tb/tb_func_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_seq_if.sv
// Request/response and func_unit bus of the multi-pass sequencer.
// master: requester + func_unit side; slave: func_seq_ctrl.
interface func_seq_if #(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned CNT_W = 2
);
   logic             start;
   logic [5:0]       op_fs;
   logic             op_bw;
   logic [SIZE-1:0]  op_a;
   logic [SIZE-1:0]  op_b;
   logic             op_cin;
   logic [CNT_W-1:0] rpt_cnt;
   logic [SIZE-1:0]  fu_f;
   logic [3:0]       fu_cvnz;
   logic [SIZE-1:0]  fu_a;
   logic [SIZE-1:0]  fu_b;
   logic [5:0]       fu_fs;
   logic             fu_cin;
   logic             fu_bw;
   logic             busy;
   logic             done;
   logic [SIZE-1:0]  result;
   logic [3:0]       cvnz;

   modport master (
      output start, op_fs, op_bw, op_a, op_b, op_cin, rpt_cnt, fu_f, fu_cvnz,
      input  fu_a, fu_b, fu_fs, fu_cin, fu_bw, busy, done, result, cvnz
   );

   modport slave (
      input  start, op_fs, op_bw, op_a, op_b, op_cin, rpt_cnt, fu_f, fu_cvnz,
      output fu_a, fu_b, fu_fs, fu_cin, fu_bw, busy, done, result, cvnz
   );
endinterface

// File: rtl/func_seq_ctrl.sv
// Multi-pass sequencer in front of func_unit: repeats one op N = rpt_cnt+1 times with feedback.
// Optional FUNC_SEQ_CARRY_CHAIN_EN: feed each pass's carry into the next pass's Cin.
module func_seq_ctrl #(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned CNT_W = 2
) (
   input logic       clk,
   input logic       rst_n,
   func_seq_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [SIZE-1:0]  fu_a_q, fu_a_d;
   logic [SIZE-1:0]  fu_b_q, fu_b_d;
   logic [5:0]       fu_fs_q, fu_fs_d;
   logic             fu_cin_q, fu_cin_d;
   logic             fu_bw_q, fu_bw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rpt_q, rpt_d;
   logic [SIZE-1:0]  result_q, result_d;
   logic [3:0]       cvnz_q, cvnz_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         fu_a_q   <= '0;
         fu_b_q   <= '0;
         fu_fs_q  <= '0;
         fu_cin_q <= 1'b0;
         fu_bw_q  <= 1'b0;
         cnt_q    <= '0;
         rpt_q    <= '0;
         result_q <= '0;
         cvnz_q   <= '0;
      end else begin
         state_q  <= state_d;
         fu_a_q   <= fu_a_d;
         fu_b_q   <= fu_b_d;
         fu_fs_q  <= fu_fs_d;
         fu_cin_q <= fu_cin_d;
         fu_bw_q  <= fu_bw_d;
         cnt_q    <= cnt_d;
         rpt_q    <= rpt_d;
         result_q <= result_d;
         cvnz_q   <= cvnz_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fu_a_d   = fu_a_q;
      fu_b_d   = fu_b_q;
      fu_fs_d  = fu_fs_q;
      fu_cin_d = fu_cin_q;
      fu_bw_d  = fu_bw_q;
      cnt_d    = cnt_q;
      rpt_d    = rpt_q;
      result_d = result_q;
      cvnz_d   = cvnz_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d  = StRun;
               fu_a_d   = bus.op_a;
               fu_b_d   = bus.op_b;
               fu_fs_d  = bus.op_fs;
               fu_cin_d = bus.op_cin;
               fu_bw_d  = bus.op_bw;
               rpt_d    = bus.rpt_cnt;
               cnt_d    = '0;
            end
         end
         StRun: begin
            // Compare before increment so rpt_cnt = all-ones never needs a wrap.
            if (cnt_q == rpt_q) begin
               result_d = bus.fu_f;
               cvnz_d   = bus.fu_cvnz;
               state_d  = StDone;
            end else begin
               // FS[2] selects which operand is the destination of the fed-back F.
               if (fu_fs_q[2]) begin
                  fu_a_d = bus.fu_f;
               end else begin
                  fu_b_d = bus.fu_f;
               end
`ifdef FUNC_SEQ_CARRY_CHAIN_EN
               fu_cin_d = bus.fu_cvnz[3];
`else
               fu_cin_d = fu_cin_q;
`endif
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
            fu_fs_d = '0;
            fu_bw_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.fu_a   = fu_a_q;
   assign bus.fu_b   = fu_b_q;
   assign bus.fu_fs  = fu_fs_q;
   assign bus.fu_cin = fu_cin_q;
   assign bus.fu_bw  = fu_bw_q;
   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone);
   assign bus.result = result_q;
   assign bus.cvnz   = cvnz_q;

endmodule

// File: tb/tb_func_seq_ctrl.sv
// Scoreboard bench for func_seq_ctrl with a behavioural func_unit model.
// Honours FUNC_SEQ_CARRY_CHAIN_EN when the same define is given to the build.
module tb_func_seq_ctrl;
   localparam int unsigned SIZE  = 16;
   localparam int unsigned CNT_W = 2;

   localparam logic [5:0] FS_ADD  = 6'h00;
   localparam logic [5:0] FS_RRA  = 6'h01;
   localparam logic [5:0] FS_RRC  = 6'h02;
   localparam logic [5:0] FS_ADDA = 6'h04;  // FS[2]=1: F goes back into A

   typedef struct {
      logic [15:0] result;
      logic [3:0]  cvnz;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   func_seq_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

   func_seq_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   busy_until = 0;
   int   done_seen = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];
   logic [15:0] exp_b_tbl [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [19:0] fu_model(input logic [5:0] fs, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
      logic [16:0] s;
      logic [15:0] f;
      logic        c, v;
      s = '0;
      f = '0;
      c = 1'b0;
      v = 1'b0;
      case (fs)
         FS_ADD, FS_ADDA: begin
            s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            f = s[15:0];
            c = s[16];
            v = (a[15] == b[15]) && (f[15] != a[15]);
         end
         FS_RRA: begin f = {b[15], b[15:1]}; c = b[0]; end
         FS_RRC: begin f = {cin, b[15:1]};   c = b[0]; end
         default: f = a ^ b;
      endcase
      return {c, v, f[15], (f == 16'h0000), f};
   endfunction

   function automatic exp_t ref_op(input logic [5:0] fs, input logic [15:0] a0,
                                   input logic [15:0] b0, input logic cin0,
                                   input logic [1:0] rpt, input int k);
      exp_t        e;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [19:0] r;
      int          n;
      a = a0;
      b = b0;
      cin = cin0;
      r = '0;
      n = int'(rpt) + 1;
      for (int p = 0; p < n; p++) begin
         r = fu_model(fs, a, b, cin);
         if (p < n - 1) begin
            if (fs[2]) a = r[15:0];
            else       b = r[15:0];
`ifdef FUNC_SEQ_CARRY_CHAIN_EN
            cin = r[19];
`endif
         end
      end
      e.result = r[15:0];
      e.cvnz = r[19:16];
      e.done_cyc = k + n + 1;
      return e;
   endfunction

   always_comb {bus.fu_cvnz, bus.fu_f} = fu_model(bus.fu_fs, bus.fu_a, bus.fu_b, bus.fu_cin);

   // Acceptance model: the bench decides on its own when a start is taken.
   always @(posedge clk) begin
      if (!rst_n) begin
         sb.delete();
         busy_until <= 0;
      end else if (bus.start && cyc >= busy_until) begin
         sb.push_back(ref_op(bus.op_fs, bus.op_a, bus.op_b, bus.op_cin, bus.rpt_cnt, cyc));
         busy_until <= cyc + int'(bus.rpt_cnt) + 3;
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", {31'b0, bus.busy}, {31'b0, (cyc < busy_until)});
         if (sb.size() > 0 && sb[0].done_cyc == cyc) begin
            check("done_pulse", {31'b0, bus.done}, 32'd1);
            check("result", {16'b0, bus.result}, {16'b0, sb[0].result});
            check("cvnz", {28'b0, bus.cvnz}, {28'b0, sb[0].cvnz});
            void'(sb.pop_front());
         end else begin
            check("done_low", {31'b0, bus.done}, 32'd0);
         end
         if (bus.done) done_seen <= done_seen + 1;
      end
   end

   task automatic start_op(input logic [5:0] fs, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [1:0] rpt);
      @(posedge clk);
      #1;
      bus.op_fs = fs;
      bus.op_a = a;
      bus.op_b = b;
      bus.op_cin = cin;
      bus.rpt_cnt = rpt;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op_a = 16'hDEAD;
      bus.op_b = 16'hBEEF;
      bus.op_cin = ~cin;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      exp_b_tbl[0] = 16'h8000;
      exp_b_tbl[1] = 16'hC000;
      exp_b_tbl[2] = 16'hE000;
      exp_b_tbl[3] = 16'hF000;
      bus.start = 1'b0;
      bus.op_fs = '0;
      bus.op_bw = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.op_cin = 1'b0;
      bus.rpt_cnt = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_fu_a", {16'b0, bus.fu_a}, 32'd0);
      check("rst_fu_b", {16'b0, bus.fu_b}, 32'd0);
      check("rst_fu_fs", {26'b0, bus.fu_fs}, 32'd0);
      check("rst_result", {16'b0, bus.result}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Single pass add: 0001 + FFFF -> 0000, C and Z set
      start_op(FS_ADD, 16'h0001, 16'hFFFF, 1'b0, 2'd0);
      drain();

      // Repeat arithmetic shift with per-pass operand trace, bw latched
      @(posedge clk);
      #1;
      bus.op_fs = FS_RRA;
      bus.op_a = 16'h0000;
      bus.op_b = 16'h8000;
      bus.op_cin = 1'b0;
      bus.op_bw = 1'b1;
      bus.rpt_cnt = 2'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op_b = 16'h1234;
      bus.op_bw = 1'b0;
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         check("rra_fu_b", {16'b0, bus.fu_b}, {16'b0, exp_b_tbl[p]});
         check("rra_fu_bw", {31'b0, bus.fu_bw}, 32'd1);
      end
      drain();
      check("bw_cleared", {31'b0, bus.fu_bw}, 32'd0);

      // Carry chain cases; expectations follow the configured carry mode
      start_op(FS_RRC, 16'h0000, 16'h0001, 1'b1, 2'd1);
      drain();
      start_op(FS_RRC, 16'h0000, 16'h0001, 1'b0, 2'd1);
      drain();
      start_op(FS_RRC, 16'h0000, 16'h00F3, 1'b0, 2'd3);
      drain();

      // Operand swap: pass-0 F lands in A, B untouched
      @(posedge clk);
      #1;
      bus.op_fs = FS_ADDA;
      bus.op_a = 16'h0001;
      bus.op_b = 16'h0002;
      bus.op_cin = 1'b0;
      bus.rpt_cnt = 2'd1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("swap_a0", {16'b0, bus.fu_a}, 32'h0001);
      @(negedge clk);
      check("swap_a1", {16'b0, bus.fu_a}, 32'h0003);
      check("swap_b1", {16'b0, bus.fu_b}, 32'h0002);
      drain();

      // Reset mid-run after pass 1 aborts without a done pulse
      start_op(FS_RRA, 16'h0000, 16'h4000, 1'b0, 2'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_done", {31'b0, bus.done}, 32'd0);
      check("abort_result", {16'b0, bus.result}, 32'd0);
      check("abort_cvnz", {28'b0, bus.cvnz}, 32'd0);
      check("abort_fu_fs", {26'b0, bus.fu_fs}, 32'd0);
      d0 = done_seen;
      repeat (10) @(negedge clk);
      check("abort_no_done", done_seen, d0);

      // Start held high with changing operands: only idle-cycle samples are taken
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op_fs = FS_ADD;
      bus.rpt_cnt = 2'd3;
      for (int i = 0; i < 20; i++) begin
         bus.op_a = 16'($urandom);
         bus.op_b = 16'($urandom);
         bus.op_cin = 1'($urandom);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      drain();
      check("burst_done_count", done_seen - d0, 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
